dbus_arbiter: RTL and testbench

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arbiter.sv | 137 +++++++++++++
 tb/tb_dbus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: the MEM stage (port 0) has default priority, and the
// page-table walker (port 1) is forced in after STARVE_LIMIT port-0 wins while it waits.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | no owner, bus request held invalid, arbitration on the next edge
// GNT0  | port 0 owns the bus for one transaction
// GNT1  | port 1 owns the bus for one transaction
// LOCK0 | port 0 keeps the bus between transactions (AMO / LR-SC)
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq0,
  input  logic       lock0,
  output dbus_resp_t dresp0,
  input  dbus_req_t  dreq1,
  output dbus_resp_t dresp1,
  output dbus_req_t  dreq_o,
  input  dbus_resp_t dresp_i,
  output logic [1:0] grant,
  output logic       proto_err
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, LOCK0} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          proto_set;
  logic          done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (proto_set) proto_err <= 1'b1;
    end
  end

  // dreq_o is zero in IDLE, so completion can only be seen while someone owns the bus
  assign done = dreq_o.valid & dresp_i.addr_ok & dresp_i.data_ok;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    proto_set  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq0.valid && dreq1.valid) begin
          // counter never exceeds LIMIT, so the increment below saturates by construction
          if (starve_cnt == LIMIT) begin
            state_nxt  = GNT1;
            starve_nxt = '0;
          end else begin
            state_nxt  = GNT0;
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (dreq0.valid) begin
          state_nxt = GNT0;
        end else if (dreq1.valid) begin
          state_nxt  = GNT1;
          starve_nxt = '0;
        end
      end
      GNT0: begin
        if (!dreq0.valid) begin
          proto_set = 1'b1;
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = lock0 ? LOCK0 : IDLE;
        end
      end
      GNT1: begin
        if (!dreq1.valid) begin
          proto_set = 1'b1;
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = IDLE;
        end
      end
      LOCK0: begin
        // valid may legitimately drop here between the locked transactions
        if (dreq0.valid) begin
          if (done && !lock0) state_nxt = IDLE;
        end else if (!lock0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dreq_o = '0;
    dresp0 = '0;
    dresp1 = '0;
    grant  = 2'b00;
    case (state)
      GNT0, LOCK0: begin
        dreq_o = dreq0;
        dresp0 = dresp_i;
        grant  = 2'b01;
      end
      GNT1: begin
        dreq_o = dreq1;
        dresp1 = dresp_i;
        grant  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed vector table, hand-written reset corner cases,
// then randomized traffic checked against an owner/lock reference model.
module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  dbus_req_t  dreq0, dreq1, dreq_o;
  dbus_resp_t dresp0, dresp1, dresp_i;
  logic       lock0;
  logic [1:0] grant;
  logic       proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .dreq0(dreq0), .lock0(lock0), .dresp0(dresp0),
    .dreq1(dreq1), .dresp1(dresp1),
    .dreq_o(dreq_o), .dresp_i(dresp_i),
    .grant(grant), .proto_err(proto_err)
  );

  typedef struct {
    bit v0, lk, v1, aok, dok;
    logic [1:0] g;
    bit vo, d0, d1, pe;
  } vec_t;

  vec_t tbl[$];

  // reference model: who owns the bus, whether it is held locked, fairness count
  int m_owner;
  bit m_locked;
  int m_starve;
  bit m_perr;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_locked = 0;
    m_starve = 0;
    m_perr   = 0;
  endtask

  task automatic check_outputs(input string tag);
    dbus_req_t  er;
    dbus_resp_t e0, e1;
    logic [1:0] eg;
    er = '0; e0 = '0; e1 = '0; eg = 2'b00;
    if (m_owner == 0) begin
      er = dreq0; e0 = dresp_i; eg = 2'b01;
    end else if (m_owner == 1) begin
      er = dreq1; e1 = dresp_i; eg = 2'b10;
    end
    check({tag, ".grant"}, 80'(grant), 80'(eg));
    check({tag, ".dreq_o"}, 80'(dreq_o), 80'(er));
    check({tag, ".dresp0"}, 80'(dresp0), 80'(e0));
    check({tag, ".dresp1"}, 80'(dresp1), 80'(e1));
    check({tag, ".proto_err"}, 80'(proto_err), 80'(m_perr));
  endtask

  // advance the model across one clock edge using the inputs currently driven
  task automatic model_step();
    bit v0, v1, ack;
    v0  = dreq0.valid;
    v1  = dreq1.valid;
    ack = dresp_i.addr_ok && dresp_i.data_ok;
    if (m_owner == -1) begin
      m_locked = 0;
      if (v0 && v1) begin
        if (m_starve == LIMIT) begin
          m_owner = 1; m_starve = 0;
        end else begin
          m_owner = 0; m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end
      end else if (v0) begin
        m_owner = 0;
      end else if (v1) begin
        m_owner = 1; m_starve = 0;
      end
    end else if (m_owner == 0) begin
      if (!m_locked && !v0) begin
        m_perr = 1; m_owner = -1;
      end else if (v0 && ack) begin
        if (lock0) m_locked = 1;
        else begin m_owner = -1; m_locked = 0; end
      end else if (m_locked && !v0 && !lock0) begin
        m_owner = -1; m_locked = 0;
      end
    end else begin
      if (!v1) begin
        m_perr = 1; m_owner = -1;
      end else if (ack) begin
        m_owner = -1;
      end
    end
  endtask

  task automatic idle_inputs();
    dreq0 = '0; dreq1 = '0; dresp_i = '0; lock0 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_table();
    logic [31:0] ea;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      dreq0   = '{valid: tbl[i].v0, we: 1'b0, wstrb: 4'hf, addr: 32'h1000 + i, wdata: 32'(i)};
      dreq1   = '{valid: tbl[i].v1, we: 1'b0, wstrb: 4'hf, addr: 32'h2000 + i, wdata: 32'(i)};
      dresp_i = '{addr_ok: tbl[i].aok, data_ok: tbl[i].dok, rdata: 32'ha000 + i};
      lock0   = tbl[i].lk;
      #1;
      ea = (tbl[i].g == 2'b01) ? 32'h1000 + i : (tbl[i].g == 2'b10) ? 32'h2000 + i : 32'h0;
      check($sformatf("tbl[%0d].grant", i), 80'(grant), 80'(tbl[i].g));
      check($sformatf("tbl[%0d].valid_o", i), 80'(dreq_o.valid), 80'(tbl[i].vo));
      check($sformatf("tbl[%0d].addr_o", i), 80'(dreq_o.addr), 80'(ea));
      check($sformatf("tbl[%0d].data_ok0", i), 80'(dresp0.data_ok), 80'(tbl[i].d0));
      check($sformatf("tbl[%0d].data_ok1", i), 80'(dresp1.data_ok), 80'(tbl[i].d1));
      check($sformatf("tbl[%0d].proto_err", i), 80'(proto_err), 80'(tbl[i].pe));
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // {v0, lock0, v1, addr_ok, data_ok, grant, valid_o, data_ok0, data_ok1, proto_err}
    tbl.push_back('{1,0,0,0,0, 2'b00, 0,0,0,0});
    tbl.push_back('{1,0,0,0,0, 2'b01, 1,0,0,0});
    tbl.push_back('{1,0,0,1,1, 2'b01, 1,1,0,0});
    tbl.push_back('{0,0,0,0,0, 2'b00, 0,0,0,0});
    for (int k = 0; k < LIMIT; k++) begin
      tbl.push_back('{1,0,1,1,1, 2'b00, 0,0,0,0});
      tbl.push_back('{1,0,1,1,1, 2'b01, 1,1,0,0});
    end
    tbl.push_back('{1,0,1,1,1, 2'b00, 0,0,0,0});
    tbl.push_back('{1,0,1,1,1, 2'b10, 1,0,1,0});
    tbl.push_back('{1,0,1,1,1, 2'b00, 0,0,0,0});
    tbl.push_back('{1,0,1,1,1, 2'b01, 1,1,0,0});
    tbl.push_back('{0,0,0,0,0, 2'b00, 0,0,0,0});
    tbl.push_back('{1,1,0,0,0, 2'b00, 0,0,0,0});
    tbl.push_back('{1,1,0,1,1, 2'b01, 1,1,0,0});
    tbl.push_back('{1,1,1,0,0, 2'b01, 1,0,0,0});
    tbl.push_back('{1,1,1,1,1, 2'b01, 1,1,0,0});
    tbl.push_back('{0,1,1,0,0, 2'b01, 0,0,0,0});
    tbl.push_back('{0,0,1,0,0, 2'b01, 0,0,0,0});
    tbl.push_back('{0,0,1,0,0, 2'b00, 0,0,0,0});
    tbl.push_back('{0,0,1,0,0, 2'b10, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 2'b10, 0,0,0,0});
    tbl.push_back('{0,0,0,0,0, 2'b00, 0,0,0,1});
    tbl.push_back('{1,0,0,0,0, 2'b00, 0,0,0,1});
    tbl.push_back('{1,0,0,1,1, 2'b01, 1,1,0,1});

    do_reset();
    run_table();

    // asynchronous reset while port 1 owns the bus, then re-grant on the first edge
    do_reset();
    @(negedge clk);
    dreq1   = '{valid: 1'b1, we: 1'b1, wstrb: 4'h3, addr: 32'h3000, wdata: 32'h55};
    dresp_i = '{addr_ok: 1'b0, data_ok: 1'b1, rdata: 32'hbeef};
    @(negedge clk);
    #1;
    check("arst.pre_grant", 80'(grant), 80'(2'b10));
    check("arst.pre_dresp1", 80'(dresp1), 80'(dresp_i));
    #1 rst = 1'b0;
    #1;
    check("arst.grant", 80'(grant), 80'(2'b00));
    check("arst.valid_o", 80'(dreq_o.valid), 80'(1'b0));
    check("arst.dresp1", 80'(dresp1), 80'(0));
    check("arst.dresp0", 80'(dresp0), 80'(0));
    check("arst.proto_err", 80'(proto_err), 80'(1'b0));
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("arst.regrant", 80'(grant), 80'(2'b10));
    check("arst.regrant_addr", 80'(dreq_o.addr), 80'(32'h3000));

    // randomized traffic in epochs, each starting from reset so proto_err can clear
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        dreq0 = '{valid: ($urandom_range(99) < 85), we: 1'($urandom), wstrb: 4'($urandom),
                  addr: $urandom, wdata: $urandom};
        dreq1 = '{valid: ($urandom_range(99) < (ep < 3 ? 90 : 60)), we: 1'($urandom),
                  wstrb: 4'($urandom), addr: $urandom, wdata: $urandom};
        dresp_i = '{addr_ok: ($urandom_range(99) < 70), data_ok: ($urandom_range(99) < 70),
                    rdata: $urandom};
        lock0 = ($urandom_range(99) < 30);
        #1;
        check_outputs($sformatf("rnd%0d", ep));
        model_step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
